// File: rtl/fdc_pkg.sv
// Shared types and default sizing for the fault-detection campaign controller.
// The optional early-exit behaviour is selected with FDC_EARLY_EXIT_EN (see fault_detect_ctrl).
package fdc_pkg;

    localparam int DEF_OUT_BITS = 25;
    localparam int DEF_PAT_CNT  = 64;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_NEXT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } fdc_state_e;

    // Pattern counter width; a single-pattern campaign still needs a 1-bit counter.
    function automatic int pat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fdc_sat_cnt.sv
// Saturating counter with synchronous clear and single-step increment enable.
module fdc_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fault_detect_ctrl.sv
// Fault-simulation campaign controller: applies PAT_CNT patterns per injected fault and
// counts faults whose CUT response ever differs from the fault-free one. Macro: FDC_EARLY_EXIT_EN.
module fault_detect_ctrl
    import fdc_pkg::*;
#(
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int PAT_CNT  = DEF_PAT_CNT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    input  logic                FIL_END,
    output logic                FIL_INC,
    output logic                TPG_EN,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    det_cnt,
    output logic [CNT_W-1:0]    tot_cnt
);

    localparam int            PW       = pat_w(PAT_CNT);
    localparam logic [PW-1:0] PAT_LAST = PW'(PAT_CNT - 1);

    fdc_state_e    state;
    fdc_state_e    state_nxt;
    logic [PW-1:0] pat_cnt;
    logic          det_flag;
    logic          mismatch;
    logic          last_pat;
    logic          early_exit;
    logic          cnt_clr;
    logic          tot_inc;
    logic          det_inc;

    // Compared combinationally so the verdict belongs to the pattern on the bus this cycle.
    assign mismatch = |(CUT_OP ^ FF_OP);
    assign last_pat = (pat_cnt == PAT_LAST);

`ifdef FDC_EARLY_EXIT_EN
    assign early_exit = det_flag;
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        TPG_EN    = 1'b0;
        FIL_INC   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clr   = 1'b0;
        tot_inc   = 1'b0;
        det_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy   = 1'b1;
                TPG_EN = 1'b1;
                if (last_pat || early_exit) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                busy    = 1'b1;
                tot_inc = 1'b1;
                det_inc = det_flag;
                // The last fault ends the campaign without asking for another injection.
                if (FIL_END) begin
                    state_nxt = ST_DONE;
                end else begin
                    FIL_INC   = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy      = 1'b1;
                state_nxt = ST_APPLY;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_APPLY;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_cnt  <= '0;
            det_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pat_cnt  <= '0;
                        det_flag <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    pat_cnt  <= pat_cnt + PW'(1);
                    det_flag <= det_flag | mismatch;
                end
                ST_SETTLE: begin
                    pat_cnt  <= '0;
                    det_flag <= 1'b0;
                end
                default: begin
                    pat_cnt  <= pat_cnt;
                    det_flag <= det_flag;
                end
            endcase
        end
    end

    // det_cnt only steps alongside tot_cnt and both saturate at the same ceiling.
    fdc_sat_cnt #(.W(CNT_W)) u_det_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (det_inc),
        .cnt (det_cnt)
    );

    fdc_sat_cnt #(.W(CNT_W)) u_tot_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (tot_inc),
        .cnt (tot_cnt)
    );

endmodule

// File: tb/tb_fault_detect_ctrl.sv
// Directed bench for fault_detect_ctrl with a small fault-injection/CUT model around it.
// Expectations follow FDC_EARLY_EXIT_EN when it is defined.
module tb_fault_detect_ctrl;

    localparam int OUT_BITS = 25;
    localparam int PAT_CNT  = 4;
    localparam int CNT_W    = 2;

    logic                clk;
    logic                rst;
    logic                start;
    logic [OUT_BITS-1:0] cut_op;
    logic [OUT_BITS-1:0] ff_op;
    logic                fil_end;
    logic                fil_inc;
    logic                tpg_en;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    det_cnt;
    logic [CNT_W-1:0]    tot_cnt;

    fault_detect_ctrl #(
        .OUT_BITS (OUT_BITS),
        .PAT_CNT  (PAT_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .CUT_OP  (cut_op),
        .FF_OP   (ff_op),
        .FIL_END (fil_end),
        .FIL_INC (fil_inc),
        .TPG_EN  (tpg_en),
        .busy    (busy),
        .done    (done),
        .det_cnt (det_cnt),
        .tot_cnt (tot_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- environment: fault injector + CUT ----------------
    int          n_faults;
    logic [31:0] cur_map;     // bit fault*4+pattern set => CUT differs on that pattern
    int          fault_idx;
    int          pat_idx;
    int          inc_cnt;
    int          tpg_total;
    int          tpg_f0;
    int          consec_err;
    logic        prev_inc;
    int          flip_bit;
    logic        mm_now;

    assign fil_end = (fault_idx == n_faults - 1);

    always_comb begin
        mm_now = 1'b0;
        if (fault_idx < 8 && pat_idx < 4) begin
            mm_now = cur_map[fault_idx*4 + pat_idx];
        end
    end

    assign cut_op = mm_now ? (ff_op ^ (OUT_BITS'(1) << flip_bit)) : ff_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_idx  <= 0;
            pat_idx    <= 0;
            inc_cnt    <= 0;
            tpg_total  <= 0;
            tpg_f0     <= 0;
            consec_err <= 0;
            prev_inc   <= 1'b0;
        end else if (start && !busy) begin
            fault_idx <= 0;
            pat_idx   <= 0;
            inc_cnt   <= 0;
            tpg_total <= 0;
            tpg_f0    <= 0;
            prev_inc  <= 1'b0;
        end else begin
            prev_inc <= fil_inc;
            if (fil_inc && prev_inc) consec_err <= consec_err + 1;
            if (fil_inc) begin
                inc_cnt   <= inc_cnt + 1;
                fault_idx <= fault_idx + 1;
                pat_idx   <= 0;
            end
            if (tpg_en) begin
                pat_idx   <= pat_idx + 1;
                tpg_total <= tpg_total + 1;
                if (fault_idx == 0) tpg_f0 <= tpg_f0 + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done_timeout"}, int'(done), 1);
    endtask

    task automatic wait_fault(input int target, input logic need_tpg, input string name);
        int k;
        k = 0;
        while (!(fault_idx == target && (!need_tpg || tpg_en)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_wait_timeout"}, int'(k < 300), 1);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] map;
        int          exp_det;
        int          exp_tot;
        int          exp_inc;
        int          exp_tpg_f0;
        int          exp_tpg_total;
    } camp_t;

    camp_t vecs[5];

    task automatic run_campaign(input camp_t v);
        n_faults = v.n;
        cur_map  = v.map;
        start_pulse();
        wait_done(v.name);
        @(negedge clk);
        chk({v.name, "_done"},      int'(done),    1);
        chk({v.name, "_busy"},      int'(busy),    0);
        chk({v.name, "_det_cnt"},   int'(det_cnt), v.exp_det);
        chk({v.name, "_tot_cnt"},   int'(tot_cnt), v.exp_tot);
        chk({v.name, "_fil_inc_n"}, inc_cnt,       v.exp_inc);
        chk({v.name, "_tpg_f0"},    tpg_f0,        v.exp_tpg_f0);
        chk({v.name, "_tpg_total"}, tpg_total,     v.exp_tpg_total);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            ff_op    = OUT_BITS'($urandom);
            flip_bit = $urandom_range(0, OUT_BITS - 1);
        end
    end

    initial begin
`ifdef FDC_EARLY_EXIT_EN
        vecs[0] = '{"no_det",     3, 32'h0000_0000, 0, 3, 2, 4, 12};
        vecs[1] = '{"det_f0_p2",  3, 32'h0000_0002, 1, 3, 2, 3, 11};
        vecs[2] = '{"single",     1, 32'h0000_0000, 0, 1, 0, 4, 4};
        vecs[3] = '{"saturate",   5, 32'h0001_1111, 3, 3, 4, 2, 10};
        vecs[4] = '{"det_f1_p4",  2, 32'h0000_0080, 1, 2, 1, 4, 8};
`else
        vecs[0] = '{"no_det",     3, 32'h0000_0000, 0, 3, 2, 4, 12};
        vecs[1] = '{"det_f0_p2",  3, 32'h0000_0002, 1, 3, 2, 4, 12};
        vecs[2] = '{"single",     1, 32'h0000_0000, 0, 1, 0, 4, 4};
        vecs[3] = '{"saturate",   5, 32'h0001_1111, 3, 3, 4, 4, 20};
        vecs[4] = '{"det_f1_p4",  2, 32'h0000_0080, 1, 2, 1, 4, 8};
`endif
        rst      = 1'b1;
        start    = 1'b0;
        n_faults = 3;
        cur_map  = '0;
        ff_op    = '0;
        flip_bit = 0;
        repeat (3) @(negedge clk);
        chk("rst_tpg_en",  int'(tpg_en),  0);
        chk("rst_fil_inc", int'(fil_inc), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_det_cnt", int'(det_cnt), 0);
        chk("rst_tot_cnt", int'(tot_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_campaign(vecs[i]);
        end

        repeat (4) @(negedge clk);
        chk("done_held", int'(done), 1);

        // Start ignored while busy: counters keep running totals.
        n_faults = 3;
        cur_map  = 32'h0000_0002;
        start_pulse();
        chk("restart_busy",      int'(busy),    1);
        chk("restart_done_low",  int'(done),    0);
        chk("restart_tot_clear", int'(tot_cnt), 0);
        wait_fault(1, 1'b0, "busy_start");
        chk("mid_tot_cnt", int'(tot_cnt), 1);
        chk("mid_det_cnt", int'(det_cnt), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy",    int'(busy),    1);
        chk("ign_tot_cnt", int'(tot_cnt), 1);
        chk("ign_det_cnt", int'(det_cnt), 1);
        wait_done("busy_start");
        chk("ign_final_det", int'(det_cnt), 1);
        chk("ign_final_tot", int'(tot_cnt), 3);
        chk("ign_final_inc", inc_cnt,       2);

        // Asynchronous reset in the middle of fault 2's APPLY window.
        start_pulse();
        wait_fault(1, 1'b1, "mid_rst");
        #2 rst = 1'b1;
        #1;
        chk("arst_tpg_en",  int'(tpg_en),  0);
        chk("arst_fil_inc", int'(fil_inc), 0);
        chk("arst_busy",    int'(busy),    0);
        chk("arst_done",    int'(done),    0);
        chk("arst_det_cnt", int'(det_cnt), 0);
        chk("arst_tot_cnt", int'(tot_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        run_campaign(vecs[0]);

        chk("fil_inc_back_to_back", consec_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_detect_ctrl.md
FAULT_DETECT_CTRL -- requirements
Module: fault_detect_ctrl

Interface
REQ-001 SHALL have parameter OUT_BITS, default 25, width of compared CUT outputs.
REQ-002 SHALL have parameter PAT_CNT, default 64, patterns applied per injected fault (>=1).
REQ-003 SHALL have parameter CNT_W, default 16, width of fault counters.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin campaign; sampled in IDLE or DONE only.
REQ-007 SHALL have port CUT_OP  input  OUT_BITS  faulty CUT response.
REQ-008 SHALL have port FF_OP  input  OUT_BITS  fault-free CUT response.
REQ-009 SHALL have port FIL_END  input  1  high when the currently injected fault is the last one.
REQ-010 SHALL have port FIL_INC  output  1  one-cycle pulse requesting the next fault injection.
REQ-011 SHALL have port TPG_EN  output  1  advance test pattern generator one step.
REQ-012 SHALL have port busy  output  1  campaign in progress.
REQ-013 SHALL have port done  output  1  campaign complete; held until start or rst.
REQ-014 SHALL have port det_cnt  output  CNT_W  faults detected.
REQ-015 SHALL have port tot_cnt  output  CNT_W  faults evaluated.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, NEXT, SETTLE, DONE.
REQ-017 IDLE/DONE + start -> APPLY; clears det_cnt, tot_cnt, pattern counter, det_flag; done deasserts same edge.
REQ-018 APPLY SHALL assert TPG_EN every cycle; mismatch = OR-reduce(CUT_OP XOR FF_OP), same-cycle, unregistered inputs.
REQ-019 APPLY SHALL set sticky det_flag on mismatch and increment pattern counter each cycle.
REQ-020 APPLY -> NEXT after exactly PAT_CNT cycles (counter == PAT_CNT-1), subject to REQ-031.
REQ-021 NEXT SHALL increment tot_cnt, add det_flag to det_cnt, deassert TPG_EN; lasts one cycle.
REQ-022 NEXT with FIL_END=1 -> DONE, no FIL_INC; with FIL_END=0 -> SETTLE with FIL_INC=1 that cycle only.
REQ-023 SETTLE SHALL last one cycle, clear det_flag and pattern counter, then -> APPLY.
REQ-024 FIL_INC SHALL never be high in two consecutive cycles.
REQ-025 det_cnt and tot_cnt SHALL saturate at 2^CNT_W-1; det_cnt <= tot_cnt always.
REQ-026 start while busy SHALL be ignored.
REQ-027 busy SHALL be high in APPLY, NEXT, SETTLE; done high only in DONE; never both.

Reset
REQ-028 rst SHALL force IDLE immediately, asynchronously, including mid-APPLY.
REQ-029 Reset values: FIL_INC=0, TPG_EN=0, busy=0, done=0, det_cnt=0, tot_cnt=0, det_flag=0.
REQ-030 rst is shared with the fault injection logic so fault index and counters restart together.

Configuration
REQ-031 With FDC_EARLY_EXIT_EN defined, APPLY SHALL exit to NEXT on the cycle after first mismatch (det_flag set); without it, all PAT_CNT patterns SHALL be applied regardless of mismatch.

Structure
REQ-032 Package fdc_pkg SHALL hold the FSM state typedef and default OUT_BITS/PAT_CNT/CNT_W constants.
REQ-033 Sub-module fdc_sat_cnt (saturating enable-increment counter) SHALL be instantiated for det_cnt and tot_cnt.

Verification
REQ-034 PAT_CNT=4, 3 faults, CUT_OP==FF_OP always -> done, tot_cnt=3, det_cnt=0, FIL_INC pulsed exactly 2 times.
REQ-035 PAT_CNT=4, mismatch on pattern 2 of fault 1 only -> det_cnt=1, tot_cnt=3; with FDC_EARLY_EXIT_EN fault 1 uses 3 TPG_EN cycles, without it 4.
REQ-036 FIL_END high on first fault -> one APPLY window, tot_cnt=1, done, FIL_INC never asserted.
REQ-037 CNT_W=2, 5 faults all detected -> det_cnt=tot_cnt=3 (saturated).
REQ-038 rst asserted mid-APPLY of fault 2 -> all outputs reset values same cycle; start afterwards -> counts restart from 0.
REQ-039 start pulsed while busy -> no counter clear, campaign totals unchanged.
